mode_ctrl: RTL and testbench
============================

MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 500, meaning clk cycles sw2 held before auto-repeat starts (range 2..65535).
REQ-002 Parameter RPT_CYC, default 100, meaning clk cycles between auto-repeat increase pulses (range 1..65535).
REQ-003 Parameter IDLE_CYC, default 10000, meaning clk cycles of no button activity before a set mode returns to general (range 2..65535).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sw1  input  1  raw mode1-select button, active high, asynchronous to clk.
REQ-007 set  input  1  raw mode2-advance button, active high, asynchronous to clk.
REQ-008 sw2  input  1  raw increase button, active high, asynchronous to clk.
REQ-009 mode1  output  2  main mode: 00 TIME, 01 DATE, 10 ALARM, 11 STOPWATCH.
REQ-010 mode2  output  2  sub mode: 00 general (G), 01/10/11 set fields per REQ-016.
REQ-011 increase  output  1  registered single-cycle increment pulse to TIME/DATE/ALARM blocks.
REQ-012 setting  output  1  registered, high exactly when mode2 != 00.

Function
REQ-013 Each raw button shall pass through a 2-flop synchronizer, then a rising-edge detector (sync2 high, previous sync2 low).
REQ-014 A raw button rising (held stable) shall affect registered outputs at the 3rd rising clk edge after it is first sampled high; fixed latency 3 edges.
REQ-015 sw1 edge: mode1 advances TIME->DATE->ALARM->STOPWATCH->TIME; mode2 forced to 00 same edge.
REQ-016 set edge sequences mode2 per mode1: TIME 00->01(HOUR)->10(MIN)->11(SEC)->00; DATE 00->01(MON)->10(DAY)->00; ALARM 00->01(HOUR)->10(MIN)->00; STOPWATCH remains 00.
REQ-017 Simultaneous sw1 and set edges: sw1 wins, set edge discarded.
REQ-018 sw2 edge: increase pulses high for exactly one cycle in every mode1/mode2 combination; downstream blocks qualify it.
REQ-019 Auto-repeat only while mode2 != 00 and sync sw2 high: hold counter counts from the edge cycle; extra pulse when count reaches HOLD_CYC, then one every RPT_CYC cycles until sw2 released.
REQ-020 Auto-repeat counter clears on sw2 release, on any mode1/mode2 change, and when mode2 == 00.
REQ-021 increase shall never be high two consecutive cycles; with RPT_CYC == 1 pulses shall occur every 2nd cycle.
REQ-022 Idle counter counts while mode2 != 00; clears on any button edge or repeat pulse; held at 0 when mode2 == 00.
REQ-023 Idle counter reaching IDLE_CYC-1 forces mode2 to 00 next edge; mode1 unchanged.
REQ-024 Idle timeout coinciding with a set or sw2 edge: the edge wins, timeout suppressed (counter cleared).
REQ-025 Internal counters 16 bits, saturating, no wrap-around.

Reset
REQ-026 reset high shall asynchronously force mode1=00, mode2=00, increase=0, setting=0, all synchronizer, edge, hold and idle state to 0.
REQ-027 reset asserted mid-hold or mid-set-mode: no increase pulse after reset release until a new sw2 rising edge is detected (sw2 held across release counts as a new edge after 3 edges).
REQ-028 Outputs change only on clk rising edge after reset deasserts.

Verification (HOLD_CYC=8, RPT_CYC=3, IDLE_CYC=20)
REQ-029 Reset, then 4 sw1 presses -> mode1 01,10,11,00, each 3 edges after press; mode2 stays 00.
REQ-030 mode1=01, set x3 -> mode2 01,10,00; setting 1,1,0; in STOPWATCH set press -> mode2 stays 00.
REQ-031 mode1=00, mode2=01, sw2 held 20 cycles -> increase at edge 3, then +8, +11, +14, +17 relative to initial pulse cadence; single pulse only when mode2=00.
REQ-032 mode1=01, mode2=10, no buttons -> mode2 00 exactly 20 cycles after last edge; a set edge at cycle 19 -> mode2 advances instead, idle restarts.
REQ-033 sw1 and set rising same cycle while mode1=00, mode2=01 -> mode1 01, mode2 00.
REQ-034 reset pulse during auto-repeat with sw2 still held -> outputs 0 immediately; first increase 3 edges after release, no repeat while mode2=00.

Source files
------------

// File: rtl/mode_ctrl_if.sv
// Button inputs and mode/increment outputs of the watch mode controller.
// The master side drives the raw buttons; the slave side is the controller.
interface mode_ctrl_if;
  logic       sw1;
  logic       set;
  logic       sw2;
  logic [1:0] mode1;
  logic [1:0] mode2;
  logic       increase;
  logic       setting;

  modport master (
    output sw1, set, sw2,
    input  mode1, mode2, increase, setting
  );

  modport slave (
    input  sw1, set, sw2,
    output mode1, mode2, increase, setting
  );
endinterface

// File: rtl/mode_ctrl.sv
// Watch mode controller: button synchronizers, mode1/mode2 sequencing,
// increment pulses with hold-to-repeat, and an idle timeout out of set mode.
//
//  mode1 state | meaning
//  M1_TIME     | time of day shown; set fields HOUR/MIN/SEC
//  M1_DATE     | date shown; set fields MON/DAY
//  M1_ALARM    | alarm shown; set fields HOUR/MIN
//  M1_SWATCH   | stopwatch; no set fields, mode2 stays general
module mode_ctrl #(
  parameter int HOLD_CYC = 500,
  parameter int RPT_CYC  = 100,
  parameter int IDLE_CYC = 10000
) (
  input logic        clk,
  input logic        reset,
  mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    M1_TIME   = 2'b00,
    M1_DATE   = 2'b01,
    M1_ALARM  = 2'b10,
    M1_SWATCH = 2'b11
  } mode1_t;

  localparam logic [15:0] HOLD_W    = 16'(HOLD_CYC);
  localparam logic [15:0] RPT_W     = 16'(RPT_CYC);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYC - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // per button: [0] metastable flop, [1] synchronized level, [2] previous level
  logic [2:0]  r_sw1_pipe;
  logic [2:0]  r_set_pipe;
  logic [2:0]  r_sw2_pipe;

  mode1_t      r_mode1;
  logic [1:0]  r_mode2;
  logic        r_inc;
  logic        r_setting;
  logic [15:0] r_hold;
  logic [15:0] r_rpt;
  logic [15:0] r_idle;

  logic        w_sw1_edge;
  logic        w_set_edge;
  logic        w_sw2_edge;
  logic        w_sw2_sync;
  logic        w_any_edge;
  logic [1:0]  w_set_max;
  logic        w_set_chg;
  logic        w_rpt;
  logic        w_timeout;
  logic        w_mode_chg;
  mode1_t      w_mode1_nxt;
  logic [1:0]  w_mode2_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw1_pipe <= 3'b000;
      r_set_pipe <= 3'b000;
      r_sw2_pipe <= 3'b000;
    end else begin
      r_sw1_pipe <= {r_sw1_pipe[1:0], bus.sw1};
      r_set_pipe <= {r_set_pipe[1:0], bus.set};
      r_sw2_pipe <= {r_sw2_pipe[1:0], bus.sw2};
    end
  end

  assign w_sw1_edge = r_sw1_pipe[1] & ~r_sw1_pipe[2];
  assign w_set_edge = r_set_pipe[1] & ~r_set_pipe[2];
  assign w_sw2_edge = r_sw2_pipe[1] & ~r_sw2_pipe[2];
  assign w_sw2_sync = r_sw2_pipe[1];
  assign w_any_edge = w_sw1_edge | w_set_edge | w_sw2_edge;

  // last set field reachable in each main mode
  always_comb begin
    w_set_max = 2'd0;
    case (r_mode1)
      M1_TIME:  w_set_max = 2'd3;
      M1_DATE:  w_set_max = 2'd2;
      M1_ALARM: w_set_max = 2'd2;
      default:  w_set_max = 2'd0;
    endcase
  end

  assign w_set_chg = w_set_edge & ~w_sw1_edge & (w_set_max != 2'd0);

  // blocked for one cycle after any pulse so increase never stays high twice
  assign w_rpt = (r_hold == HOLD_W) & w_sw2_sync & (r_mode2 != 2'd0)
               & ((r_rpt == 16'd0) | (r_rpt == RPT_W)) & ~r_inc;

  assign w_timeout = (r_mode2 != 2'd0) & (r_idle == IDLE_LAST)
                   & ~w_any_edge & ~w_rpt;

  assign w_mode_chg = w_sw1_edge | w_set_chg | w_timeout;

  always_comb begin
    w_mode1_nxt = r_mode1;
    w_mode2_nxt = r_mode2;
    if (w_sw1_edge) begin
      w_mode1_nxt = mode1_t'(r_mode1 + 2'd1);
      w_mode2_nxt = 2'd0;
    end else if (w_set_edge) begin
      w_mode2_nxt = (r_mode2 >= w_set_max) ? 2'd0 : r_mode2 + 2'd1;
    end else if (w_timeout) begin
      w_mode2_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode1   <= M1_TIME;
      r_mode2   <= 2'd0;
      r_inc     <= 1'b0;
      r_setting <= 1'b0;
      r_hold    <= 16'd0;
      r_rpt     <= 16'd0;
      r_idle    <= 16'd0;
    end else begin
      r_mode1   <= w_mode1_nxt;
      r_mode2   <= w_mode2_nxt;
      r_setting <= (w_mode2_nxt != 2'd0);
      r_inc     <= w_sw2_edge | w_rpt;

      // r_hold == 0 means no repeat armed; a fresh sw2 edge is needed to re-arm
      if (w_mode_chg | (r_mode2 == 2'd0) | ~w_sw2_sync) begin
        r_hold <= 16'd0;
        r_rpt  <= 16'd0;
      end else if (w_sw2_edge) begin
        r_hold <= 16'd1;
        r_rpt  <= 16'd0;
      end else if (r_hold != 16'd0) begin
        if (r_hold < HOLD_W)
          r_hold <= r_hold + 16'd1;
        if (w_rpt)
          r_rpt <= 16'd1;
        else if ((r_rpt != 16'd0) && (r_rpt < RPT_W))
          r_rpt <= r_rpt + 16'd1;
      end

      if ((r_mode2 == 2'd0) | w_any_edge | w_rpt | w_timeout)
        r_idle <= 16'd0;
      else if (r_idle != CNT_MAX)
        r_idle <= r_idle + 16'd1;
    end
  end

  assign bus.mode1    = r_mode1;
  assign bus.mode2    = r_mode2;
  assign bus.increase = r_inc;
  assign bus.setting  = r_setting;

endmodule

// File: tb/tb_mode_ctrl.sv
// Self-checking bench for mode_ctrl: directed scenarios plus random button
// activity, compared every cycle against a cycle-indexed behavioural model.
module tb_mode_ctrl;

  localparam int HOLD = 8;
  localparam int RPT  = 3;
  localparam int IDLE = 20;

  logic clk = 1'b0;
  logic reset;

  mode_ctrl_if bus ();

  mode_ctrl #(
    .HOLD_CYC (HOLD),
    .RPT_CYC  (RPT),
    .IDLE_CYC (IDLE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  // raw button level seen at each rising edge, indexed by edge number
  int cyc     = 8;
  int rst_cyc = 8;
  bit raw_sw1 [0:8191];
  bit raw_set [0:8191];
  bit raw_sw2 [0:8191];

  int m1, m2, t0, last_act;
  bit armed, m_inc;
  int set_fields [4] = '{3, 2, 2, 0};

  int pulses [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // button level sampled at edge k; samples up to the last reset edge are lost
  function automatic bit smp(int b, int k);
    if (k <= rst_cyc) return 1'b0;
    case (b)
      0:       return raw_sw1[k];
      1:       return raw_set[k];
      default: return raw_sw2[k];
    endcase
  endfunction

  task automatic model_reset();
    m1 = 0; m2 = 0; t0 = 0; last_act = 0;
    armed = 1'b0; m_inc = 1'b0;
    rst_cyc = cyc;
  endtask

  // a press first sampled at edge n-2 acts at edge n
  task automatic model_edge(int n);
    bit e1, es, e2, sy2, rpt, tmo, anye;
    int o1, o2;
    e1   = smp(0, n-2) & ~smp(0, n-3);
    es   = smp(1, n-2) & ~smp(1, n-3);
    e2   = smp(2, n-2) & ~smp(2, n-3);
    sy2  = smp(2, n-2);
    rpt  = armed && sy2 && (m2 != 0) && ((n - t0) >= HOLD)
           && (((n - t0 - HOLD) % RPT) == 0) && !m_inc;
    anye = e1 | es | e2;
    tmo  = (m2 != 0) && !anye && !rpt && ((n - last_act) == IDLE);
    o1 = m1;
    o2 = m2;
    if (e1) begin
      m1 = (m1 + 1) % 4;
      m2 = 0;
    end else if (es) begin
      m2 = (m2 >= set_fields[m1]) ? 0 : m2 + 1;
    end else if (tmo) begin
      m2 = 0;
    end
    m_inc = e2 | rpt;
    if (anye || rpt) last_act = n;
    if ((m1 != o1) || (m2 != o2) || (o2 == 0) || !sy2) armed = 1'b0;
    else if (e2) begin
      armed = 1'b1;
      t0 = n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    raw_sw1[cyc] = bus.sw1;
    raw_set[cyc] = bus.set;
    raw_sw2[cyc] = bus.sw2;
    if (reset) model_reset();
    else model_edge(cyc);
    #1;
    chk("mode1", 32'(bus.mode1), 32'(m1));
    chk("mode2", 32'(bus.mode2), 32'(m2));
    chk("increase", 32'(bus.increase), 32'(m_inc));
    chk("setting", 32'(bus.setting), 32'(m2 != 0));
  endtask

  task automatic drive(int b, bit v);
    case (b)
      0:       bus.sw1 = v;
      1:       bus.set = v;
      default: bus.sw2 = v;
    endcase
  endtask

  task automatic press(int b, int len);
    drive(b, 1'b1);
    repeat (len) step();
    drive(b, 1'b0);
  endtask

  task automatic tap(int b);
    press(b, 2);
    repeat (2) step();
  endtask

  initial begin
    int k;
    int rem [3];
    bit lvl [3];
    int exp_rpt [5] = '{3, 11, 14, 17, 20};

    reset = 1'b1;
    bus.sw1 = 1'b0;
    bus.set = 1'b0;
    bus.sw2 = 1'b0;
    model_reset();
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // full mode1 cycle
    repeat (4) tap(0);
    chk("mode1_wrap", 32'(bus.mode1), 32'd0);

    // DATE set fields, then STOPWATCH ignores set
    tap(0);
    repeat (3) tap(1);
    repeat (2) tap(0);
    tap(1);
    chk("swatch_set", 32'(bus.mode2), 32'd0);
    tap(0);

    // TIME HOUR: hold sw2 for 20 samples
    tap(1);
    pulses.delete();
    bus.sw2 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 21) bus.sw2 = 1'b0;
      step();
      if (bus.increase) pulses.push_back(i);
    end
    chk("rpt_count", 32'(pulses.size()), 32'd5);
    for (int i = 0; i < 5 && i < pulses.size(); i++)
      chk("rpt_at", 32'(pulses[i]), 32'(exp_rpt[i]));

    // back to general, hold sw2 again: single pulse
    repeat (3) tap(1);
    pulses.delete();
    bus.sw2 = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      if (i == 21) bus.sw2 = 1'b0;
      step();
      if (bus.increase) pulses.push_back(i);
    end
    chk("single_count", 32'(pulses.size()), 32'd1);

    // DATE DAY idle timeout
    tap(0);
    tap(1);
    press(1, 2);
    step();
    k = 0;
    while (bus.mode2 != 2'd0 && k < 40) begin
      step();
      k++;
    end
    chk("idle_len", 32'(k), 32'(IDLE));

    // set edge lands on the timeout edge
    press(1, 2);
    step();
    repeat (17) step();
    bus.set = 1'b1;
    repeat (2) step();
    bus.set = 1'b0;
    step();
    chk("idle_vs_set", 32'(bus.mode2), 32'd2);
    repeat (2) step();

    // simultaneous sw1 and set in TIME HOUR
    repeat (3) tap(0);
    tap(1);
    bus.sw1 = 1'b1;
    bus.set = 1'b1;
    repeat (2) step();
    bus.sw1 = 1'b0;
    bus.set = 1'b0;
    step();
    chk("sim_mode1", 32'(bus.mode1), 32'd1);
    chk("sim_mode2", 32'(bus.mode2), 32'd0);
    repeat (2) step();

    // reset in the middle of auto-repeat, sw2 kept held
    repeat (3) tap(0);
    tap(1);
    bus.sw2 = 1'b1;
    repeat (15) step();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_mode1", 32'(bus.mode1), 32'd0);
    chk("rst_mode2", 32'(bus.mode2), 32'd0);
    chk("rst_inc", 32'(bus.increase), 32'd0);
    chk("rst_setting", 32'(bus.setting), 32'd0);
    repeat (2) step();
    reset = 1'b0;
    pulses.delete();
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.increase) pulses.push_back(i);
    end
    chk("post_rst_count", 32'(pulses.size()), 32'd1);
    if (pulses.size() > 0) chk("post_rst_at", 32'(pulses[0]), 32'd3);
    bus.sw2 = 1'b0;
    repeat (5) step();

    // random button activity
    for (int b = 0; b < 3; b++) begin
      rem[b] = 0;
      lvl[b] = 1'b1;
    end
    for (int i = 0; i < 2000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = ~lvl[b];
          if (lvl[b])
            rem[b] = (b == 2) ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 4));
          else
            rem[b] = (b == 0) ? int'($urandom_range(20, 90)) : int'($urandom_range(1, 28));
        end
        rem[b]--;
        drive(b, lvl[b]);
      end
      step();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
